// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC register with branch/writeback redirect and IF/ID register
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_WORDS = 81
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        BranchTakenE,
   input  logic [31:0] BranchTargetE,
   input  logic        PCSrcW,
   input  logic [31:0] ResultW,
   output logic [31:0] PCF,
   input  logic [31:0] InstrF,
   output logic [31:0] InstrD,
   output logic [31:0] PCPlus8D,
   output logic        ValidD,
   output logic        FaultD,
   output logic [31:0] FetchCount
);

   localparam logic [31:0] c_IMEM_WORDS = 32'(IMEM_WORDS);

   logic [31:0] pcf_q, pcf_d;
   logic [31:0] instr_q;
   logic [31:0] pcplus8_q;
   logic        valid_q;
   logic        fault_q;
   logic [31:0] fetch_cnt_q;

   logic        w_redirect;
   logic        w_illegal;
   logic        w_load_d;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_plus8;

   assign w_redirect = BranchTakenE | PCSrcW;
   assign w_pc_plus4 = pcf_q + 32'd4;
   assign w_pc_plus8 = pcf_q + 32'd8;
   assign w_illegal  = (pcf_q[1:0] != 2'b00) || ({2'b00, pcf_q[31:2]} >= c_IMEM_WORDS);
   assign w_load_d   = !FlushD && !StallD;

   always_comb begin
      pcf_d = w_pc_plus4;
      if (BranchTakenE)
         pcf_d = BranchTargetE;
      else if (PCSrcW)
         pcf_d = ResultW;
   end

   // A redirect must win over StallF, otherwise a stalled fetch would lose the target
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcf_q <= RESET_PC;
      end else if (!StallF || w_redirect) begin
         pcf_q <= pcf_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instr_q     <= 32'd0;
         pcplus8_q   <= 32'd0;
         valid_q     <= 1'b0;
         fault_q     <= 1'b0;
         fetch_cnt_q <= 32'd0;
      end else if (FlushD) begin
         instr_q   <= 32'd0;
         pcplus8_q <= 32'd0;
         valid_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else if (w_load_d) begin
         instr_q   <= w_illegal ? 32'd0 : InstrF;
         pcplus8_q <= w_pc_plus8;
         valid_q   <= 1'b1;
         fault_q   <= w_illegal;
         if (!w_illegal)
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
   end

   assign PCF        = pcf_q;
   assign InstrD     = instr_q;
   assign PCPlus8D   = pcplus8_q;
   assign ValidD     = valid_q;
   assign FaultD     = fault_q;
   assign FetchCount = fetch_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        StallF, StallD, FlushD;
   logic        BranchTakenE, PCSrcW;
   logic [31:0] BranchTargetE, ResultW;
   logic [31:0] PCF, InstrF, InstrD, PCPlus8D, FetchCount;
   logic        ValidD, FaultD;

   int vecs = 0;
   int miss = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(81)) dut (
      .clk          (clk),
      .reset        (reset),
      .StallF       (StallF),
      .StallD       (StallD),
      .FlushD       (FlushD),
      .BranchTakenE (BranchTakenE),
      .BranchTargetE(BranchTargetE),
      .PCSrcW       (PCSrcW),
      .ResultW      (ResultW),
      .PCF          (PCF),
      .InstrF       (InstrF),
      .InstrD       (InstrD),
      .PCPlus8D     (PCPlus8D),
      .ValidD       (ValidD),
      .FaultD       (FaultD),
      .FetchCount   (FetchCount)
   );

   // Instruction memory image: each word encodes its own byte address
   assign InstrF = 32'hE000_0000 | PCF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed state packed as {PCF, InstrD, PCPlus8D, ValidD, FaultD, FetchCount}
   function automatic logic [129:0] snap();
      return {PCF, InstrD, PCPlus8D, ValidD, FaultD, FetchCount};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [129:0] got;
      reset = 1'b0;
      StallF = 0; StallD = 0; FlushD = 0;
      BranchTakenE = 0; BranchTargetE = 0; PCSrcW = 0; ResultW = 0;
      #2;
      got = snap();
      vecs++;
      if (got !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0}) begin
         miss++; $display("FAIL reset_state: got %h want all zero", got);
      end
      tick(); tick();
      got = snap();
      vecs++;
      if (got !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0}) begin
         miss++; $display("FAIL reset_held: got %h want all zero", got);
      end
      reset = 1'b1;
   endtask

   task automatic test_sequential();
      logic [129:0] got;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h4, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd1}) begin
         miss++; $display("FAIL seq_edge1: got %h want %h", got, {32'h4, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd1});
      end
      tick(); tick();
      got = snap(); vecs++;
      if (got !== {32'hC, 32'hE000_0008, 32'h10, 1'b1, 1'b0, 32'd3}) begin
         miss++; $display("FAIL seq_edge3: got %h want %h", got, {32'hC, 32'hE000_0008, 32'h10, 1'b1, 1'b0, 32'd3});
      end
   endtask

   task automatic test_branch_stall();
      logic [129:0] got;
      tick();
      StallF = 1;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h10, 32'hE000_0010, 32'h18, 1'b1, 1'b0, 32'd5}) begin
         miss++; $display("FAIL stallf_hold: got %h want %h", got, {32'h10, 32'hE000_0010, 32'h18, 1'b1, 1'b0, 32'd5});
      end
      BranchTakenE = 1; BranchTargetE = 32'h40;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h40, 32'hE000_0010, 32'h18, 1'b1, 1'b0, 32'd6}) begin
         miss++; $display("FAIL branch_over_stall: got %h want %h", got, {32'h40, 32'hE000_0010, 32'h18, 1'b1, 1'b0, 32'd6});
      end
      BranchTakenE = 0; StallF = 0;
   endtask

   task automatic test_priority();
      logic [129:0] got;
      BranchTakenE = 1; BranchTargetE = 32'h40; PCSrcW = 1; ResultW = 32'h80;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h40, 32'hE000_0040, 32'h48, 1'b1, 1'b0, 32'd7}) begin
         miss++; $display("FAIL branch_priority: got %h want %h", got, {32'h40, 32'hE000_0040, 32'h48, 1'b1, 1'b0, 32'd7});
      end
      BranchTakenE = 0;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h80, 32'hE000_0040, 32'h48, 1'b1, 1'b0, 32'd8}) begin
         miss++; $display("FAIL pcsrcw_redirect: got %h want %h", got, {32'h80, 32'hE000_0040, 32'h48, 1'b1, 1'b0, 32'd8});
      end
      ResultW = 32'hFFFF_FFFC;
      tick();
      got = snap(); vecs++;
      if (got !== {32'hFFFF_FFFC, 32'hE000_0080, 32'h88, 1'b1, 1'b0, 32'd9}) begin
         miss++; $display("FAIL redirect_top: got %h want %h", got, {32'hFFFF_FFFC, 32'hE000_0080, 32'h88, 1'b1, 1'b0, 32'd9});
      end
      PCSrcW = 0;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h0, 32'h0, 32'h4, 1'b1, 1'b1, 32'd9}) begin
         miss++; $display("FAIL pc_wrap: got %h want %h", got, {32'h0, 32'h0, 32'h4, 1'b1, 1'b1, 32'd9});
      end
   endtask

   task automatic test_flush_stall();
      logic [129:0] got;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h4, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd10}) begin
         miss++; $display("FAIL after_wrap: got %h want %h", got, {32'h4, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd10});
      end
      StallD = 1;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h8, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd10}) begin
         miss++; $display("FAIL stalld_edge1: got %h want %h", got, {32'h8, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd10});
      end
      tick();
      got = snap(); vecs++;
      if (got !== {32'hC, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd10}) begin
         miss++; $display("FAIL stalld_edge2: got %h want %h", got, {32'hC, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd10});
      end
      FlushD = 1;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'd10}) begin
         miss++; $display("FAIL flush_over_stall: got %h want %h", got, {32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'd10});
      end
      FlushD = 0; StallD = 0;
   endtask

   task automatic test_illegal();
      logic [129:0] got;
      PCSrcW = 1; ResultW = 32'h144;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h144, 32'hE000_0010, 32'h18, 1'b1, 1'b0, 32'd11}) begin
         miss++; $display("FAIL redirect_144: got %h want %h", got, {32'h144, 32'hE000_0010, 32'h18, 1'b1, 1'b0, 32'd11});
      end
      PCSrcW = 0; StallF = 1;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h144, 32'h0, 32'h14C, 1'b1, 1'b1, 32'd11}) begin
         miss++; $display("FAIL fault_word81: got %h want %h", got, {32'h144, 32'h0, 32'h14C, 1'b1, 1'b1, 32'd11});
      end
      PCSrcW = 1; ResultW = 32'h2;
      tick();
      ResultW = 32'h140;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h140, 32'h0, 32'hA, 1'b1, 1'b1, 32'd11}) begin
         miss++; $display("FAIL fault_misaligned: got %h want %h", got, {32'h140, 32'h0, 32'hA, 1'b1, 1'b1, 32'd11});
      end
      PCSrcW = 0;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h140, 32'hE000_0140, 32'h148, 1'b1, 1'b0, 32'd12}) begin
         miss++; $display("FAIL legal_word80: got %h want %h", got, {32'h140, 32'hE000_0140, 32'h148, 1'b1, 1'b0, 32'd12});
      end
      StallF = 0;
   endtask

   task automatic test_async_reset();
      logic [129:0] got;
      PCSrcW = 1; ResultW = 32'h20;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h20, 32'hE000_0140, 32'h148, 1'b1, 1'b0, 32'd13}) begin
         miss++; $display("FAIL pre_reset: got %h want %h", got, {32'h20, 32'hE000_0140, 32'h148, 1'b1, 1'b0, 32'd13});
      end
      PCSrcW = 0; StallF = 1; BranchTakenE = 1; BranchTargetE = 32'h40;
      #2;
      reset = 1'b0;
      #1;
      got = snap(); vecs++;
      if (got !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0}) begin
         miss++; $display("FAIL async_reset: got %h want all zero", got);
      end
      tick();
      got = snap(); vecs++;
      if (got !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0}) begin
         miss++; $display("FAIL reset_pending_discard: got %h want all zero", got);
      end
      reset = 1'b1; BranchTakenE = 0; StallF = 0;
      tick();
      got = snap(); vecs++;
      if (got !== {32'h4, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd1}) begin
         miss++; $display("FAIL restart: got %h want %h", got, {32'h4, 32'hE000_0000, 32'h8, 1'b1, 1'b0, 32'd1});
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch_stall();
      test_priority();
      test_flush_stall();
      test_illegal();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule

`default_nettype wire
